// File: rtl/kj11_stk_trap_seq_if.sv
// kj11_stk_trap_seq_if
//   Bundles the stack-limit trap sequencer's signals between the KJ11
//   comparator, the CPU microsequencer and the sequencer itself.
//   master : CPU/KJ11 side; drives init, stk_ref, eovfl, eovfl_stop,
//            instr_end, trap_ack, err_clr and observes the sequencer outputs.
//   slave  : sequencer side; drives ckovf, red_abort, force_sp, sp_value,
//            trap_req, trap_vec, halt_req, err_bits.
interface kj11_stk_trap_seq_if;
   logic        init;
   logic        stk_ref;
   logic        eovfl;
   logic        eovfl_stop;
   logic        instr_end;
   logic        trap_ack;
   logic        err_clr;
   logic        ckovf;
   logic        red_abort;
   logic        force_sp;
   logic [15:0] sp_value;
   logic        trap_req;
   logic [7:0]  trap_vec;
   logic        halt_req;
   logic [1:0]  err_bits;

   modport master (
      output init, stk_ref, eovfl, eovfl_stop, instr_end, trap_ack, err_clr,
      input  ckovf, red_abort, force_sp, sp_value, trap_req, trap_vec,
             halt_req, err_bits
   );

   modport slave (
      input  init, stk_ref, eovfl, eovfl_stop, instr_end, trap_ack, err_clr,
      output ckovf, red_abort, force_sp, sp_value, trap_req, trap_vec,
             halt_req, err_bits
   );
endinterface

// File: rtl/kj11_stk_trap_seq.sv
// kj11_stk_trap_seq
//   Stack-overflow trap sequencer downstream of the KJ11 stack-limit
//   comparator. A yellow-zone push defers a trap to VEC until end of
//   instruction; a red-zone push aborts the bus cycle, forces SP to RED_SP
//   and traps. A red push while the red trap is still pending halts the CPU.
// Ports
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      kj11_stk_trap_seq_if.slave (init, stk_ref, eovfl, eovfl_stop,
//            instr_end, trap_ack, err_clr in; ckovf, red_abort, force_sp,
//            sp_value, trap_req, trap_vec, halt_req, err_bits out)
// Build option
//   KJ11_STK_ERR_REG_EN : when defined, err_bits carries sticky red/yellow
//   status for the CPU error register; otherwise err_bits is 0 and err_clr
//   is ignored.
module kj11_stk_trap_seq #(
   parameter logic [7:0]  VEC    = 8'o004,
   parameter logic [15:0] RED_SP = 16'o000004
) (
   input logic               clk,
   input logic               reset_n,
   kj11_stk_trap_seq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, YEL_PEND, YEL_TRAP, RED_ABORT, RED_LOADSP, RED_TRAP, HALT
   } state_t;

   state_t state, state_nxt;
   logic   red_hit, yel_hit;

   assign red_hit = bus.stk_ref & bus.eovfl_stop;
   assign yel_hit = bus.stk_ref & bus.eovfl & ~bus.eovfl_stop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Outputs are pure state decodes, so each one changes only at a clock
   // edge (or immediately on reset); ckovf alone follows stk_ref directly.
   always_comb begin
      state_nxt     = state;
      bus.red_abort = 1'b0;
      bus.force_sp  = 1'b0;
      bus.trap_req  = 1'b0;
      bus.halt_req  = 1'b0;
      bus.ckovf     = 1'b0;
      case (state)
         IDLE: begin
            bus.ckovf = bus.stk_ref;
            if (red_hit)      state_nxt = RED_ABORT;
            else if (yel_hit) state_nxt = YEL_PEND;
         end
         YEL_PEND: begin
            bus.ckovf = bus.stk_ref;
            // Red preempts the deferred yellow trap; extra yellows are dropped.
            if (red_hit)            state_nxt = RED_ABORT;
            else if (bus.instr_end) state_nxt = YEL_TRAP;
         end
         YEL_TRAP: begin
            bus.trap_req = 1'b1;
            // The trap's own pushes can go red, and red beats the ack.
            if (red_hit)           state_nxt = RED_ABORT;
            else if (bus.trap_ack) state_nxt = IDLE;
         end
         RED_ABORT: begin
            bus.red_abort = 1'b1;
            state_nxt     = RED_LOADSP;
         end
         RED_LOADSP: begin
            bus.force_sp = 1'b1;
            state_nxt    = RED_TRAP;
         end
         RED_TRAP: begin
            bus.trap_req = 1'b1;
            // Second red before the ack is a double error.
            if (red_hit)           state_nxt = HALT;
            else if (bus.trap_ack) state_nxt = IDLE;
         end
         HALT: begin
            bus.halt_req = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      if (bus.init) state_nxt = IDLE;
   end

   assign bus.trap_vec = bus.trap_req ? VEC : 8'd0;
   assign bus.sp_value = RED_SP;

`ifdef KJ11_STK_ERR_REG_EN
   logic [1:0] err_q;
   logic       red_set, yel_set;

   assign red_set = (state_nxt == RED_ABORT) && (state != RED_ABORT);
   assign yel_set = (state_nxt == YEL_PEND)  && (state != YEL_PEND);

   // Set dominates a same-cycle clear so no event is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      err_q <= 2'b00;
      else if (bus.init) err_q <= 2'b00;
      else               err_q <= (bus.err_clr ? 2'b00 : err_q) | {red_set, yel_set};
   end

   assign bus.err_bits = err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.err_bits   = 2'b00;
`endif

endmodule

// File: tb/tb_kj11_stk_trap_seq.sv
module tb_kj11_stk_trap_seq;
   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   kj11_stk_trap_seq_if bus();

   kj11_stk_trap_seq dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   // Reference model: what the sequencer is doing, in plain terms.
   bit       m_halt;   // double error latched
   bit       m_pend;   // yellow trap waiting for end of instruction
   bit       m_ytrap;  // yellow trap being requested
   int       m_red;    // 0 none, 1 aborting, 2 loading SP, 3 requesting trap
   bit [1:0] m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_halt = 0; m_pend = 0; m_ytrap = 0; m_red = 0; m_err = 2'b00;
   endtask

   task automatic model_edge();
      bit       rh, yh;
      bit [1:0] set;
      rh  = bus.stk_ref && bus.eovfl_stop;
      yh  = bus.stk_ref && bus.eovfl && !bus.eovfl_stop;
      set = 2'b00;
      if (!reset_n || bus.init) begin
         model_clear();
         return;
      end
      if (m_halt) begin
         // stays halted
      end else if (m_red == 3) begin
         if (rh) begin m_halt = 1; m_red = 0; end
         else if (bus.trap_ack) m_red = 0;
      end else if (m_red != 0) begin
         m_red++;
      end else if (rh) begin
         m_red = 1; m_pend = 0; m_ytrap = 0; set[1] = 1;
      end else if (m_ytrap) begin
         if (bus.trap_ack) m_ytrap = 0;
      end else if (m_pend) begin
         if (bus.instr_end) begin m_pend = 0; m_ytrap = 1; end
      end else if (yh) begin
         m_pend = 1; set[0] = 1;
      end
      m_err = (bus.err_clr ? 2'b00 : m_err) | set;
   endtask

   task automatic check_outs();
      bit trap;
      trap = (m_red == 3) || m_ytrap;
      chk("red_abort", bus.red_abort, m_red == 1);
      chk("force_sp",  bus.force_sp,  m_red == 2);
      chk("sp_value",  bus.sp_value,  16'o000004);
      chk("trap_req",  bus.trap_req,  trap);
      chk("trap_vec",  bus.trap_vec,  trap ? 8'o004 : 8'd0);
      chk("halt_req",  bus.halt_req,  m_halt);
`ifdef KJ11_STK_ERR_REG_EN
      chk("err_bits",  bus.err_bits,  m_err);
`else
      chk("err_bits",  bus.err_bits,  2'b00);
`endif
   endtask

   // Inputs were applied at the preceding negedge; check ckovf against them,
   // clock them in, then check the registered outputs at the next negedge.
   task automatic step();
      #1;
      chk("ckovf", bus.ckovf, bus.stk_ref && !m_ytrap && m_red == 0 && !m_halt);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outs();
   endtask

   task automatic idle_in();
      bus.init = 0; bus.stk_ref = 0; bus.eovfl = 0; bus.eovfl_stop = 0;
      bus.instr_end = 0; bus.trap_ack = 0; bus.err_clr = 0;
   endtask

   task automatic push(input bit yel, input bit red);
      bus.stk_ref = 1; bus.eovfl = yel; bus.eovfl_stop = red;
      step();
      idle_in();
   endtask

   initial begin
      idle_in();
      reset_n = 0;
      model_clear();
      repeat (3) step();
      reset_n = 1;
      step();

      // Yellow trap
      push(1, 0);
      repeat (4) step();
      bus.instr_end = 1; step(); idle_in();
      bus.stk_ref = 1; step(); idle_in();   // push during YEL_TRAP: ckovf gated
      bus.trap_ack = 1; step(); idle_in();
      bus.stk_ref = 1; step(); idle_in();   // push in IDLE without hit: ckovf=1
      step();

      // Red sequence
      push(0, 1);
      repeat (3) step();
      bus.trap_ack = 1; step(); idle_in();
      step();

      // Preemption: yellow pending, then red, then late instr_end
      bus.err_clr = 1; step(); idle_in();
      push(1, 0);
      push(1, 0);                            // second yellow ignored
      push(0, 1);
      bus.instr_end = 1; step(); idle_in();
      repeat (2) step();
      bus.trap_ack = 1; step(); idle_in();
      step();

      // Double error: red during red trap, same cycle as ack
      push(0, 1);
      repeat (2) step();
      bus.stk_ref = 1; bus.eovfl_stop = 1; bus.trap_ack = 1; step(); idle_in();
      repeat (20) step();
      bus.init = 1; step(); idle_in();
      step();

      // Async reset during RED_LOADSP, between edges
      push(0, 1);
      step();                                // now in RED_LOADSP
      #2 reset_n = 0;
      #1;
      chk("async force_sp", bus.force_sp,  1'b0);
      chk("async trap_req", bus.trap_req,  1'b0);
      chk("async red_abrt", bus.red_abort, 1'b0);
      chk("async halt_req", bus.halt_req,  1'b0);
      chk("async err_bits", bus.err_bits,  2'b00);
      model_clear();
      @(negedge clk);
      repeat (2) step();
      reset_n = 1;
      step();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.stk_ref    = ($urandom_range(0, 99) < 50);
         bus.eovfl      = ($urandom_range(0, 99) < 30);
         bus.eovfl_stop = ($urandom_range(0, 99) < 8);
         bus.instr_end  = ($urandom_range(0, 99) < 30);
         bus.trap_ack   = ($urandom_range(0, 99) < 30);
         bus.err_clr    = ($urandom_range(0, 99) < 10);
         bus.init       = ($urandom_range(0, 99) < 3);
         step();
      end
      idle_in();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/kj11_stk_trap_seq.md
Name: kj11_stk_trap_seq

Overview:
- Stack-overflow trap sequencer, directly downstream of the KJ11 stack-limit comparator.
- Consumes the comparator's eovfl (yellow zone) and eovfl_stop (red zone) flags; drives back its ckovf check-qualify input.
- Yellow zone: a deferred trap to vector 004 at end of instruction.
- Red zone: aborts the stack cycle, forces SP to 4, then traps; a red violation during the red trap halts the CPU.
- Sits between the KJ11 and the CPU microsequencer trap/abort logic.

Parameters:
- VEC, 8'o004, trap vector presented on trap_vec.
- RED_SP, 16'o000004, value loaded into kernel SP on a red-zone abort.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- init  in  1  bus INIT; synchronous return to IDLE.
- stk_ref  in  1  current DATO is a kernel-mode stack push via SP (one-cycle strobe at address-valid).
- eovfl  in  1  KJ11 yellow-zone result (already ANDed with ckovf).
- eovfl_stop  in  1  KJ11 red-zone result (unqualified).
- instr_end  in  1  microcode service point, end of instruction.
- trap_ack  in  1  microcode has taken the trap (vector fetch started).
- ckovf  out  1  to KJ11: enable yellow check.
- red_abort  out  1  one-cycle abort of the current bus cycle.
- force_sp  out  1  one-cycle strobe: SP <= sp_value.
- sp_value  out  16  RED_SP constant.
- trap_req  out  1  trap request to microcode.
- trap_vec  out  8  VEC while trap_req is high, else 0.
- halt_req  out  1  double-error halt; held until init.
- err_bits  out  2  [1]=red, [0]=yellow sticky status (see Optional Feature).
- err_clr  in  1  clear err_bits.

Behaviour:
- Reset: all outputs 0, state IDLE. reset_n asserted mid-sequence clears immediately, without waiting for clk.
- init: at next clk edge, state IDLE, all outputs 0, halt_req cleared. init has priority over every other event.
- ckovf = stk_ref & (state==IDLE | state==YEL_PEND), combinational. Yellow is not rechecked during trap sequencing.
- red_hit = stk_ref & eovfl_stop. yel_hit = stk_ref & eovfl & ~eovfl_stop.
- States and transitions:
  - IDLE: red_hit -> RED_ABORT; yel_hit -> YEL_PEND.
  - YEL_PEND: red_hit -> RED_ABORT (red preempts; yellow discarded); instr_end -> YEL_TRAP; further yel_hit ignored (single pending trap).
  - YEL_TRAP: trap_req=1; trap_ack -> IDLE, trap_req dropped the same edge. red_hit -> RED_ABORT. The trap's own pushes can go red.
  - RED_ABORT: red_abort=1 for exactly one cycle -> RED_LOADSP.
  - RED_LOADSP: force_sp=1 for exactly one cycle -> RED_TRAP.
  - RED_TRAP: trap_req=1 until trap_ack -> IDLE. red_hit while here (second red before ack) -> HALT.
  - HALT: halt_req=1, trap_req=0; exits only on init or reset_n.
- Latency, registered outputs:
  - red: red_hit at edge N; red_abort high in cycle N+1, force_sp N+2, trap_req from N+3.
  - yellow: instr_end at edge M; trap_req from M+1.
- Simultaneous events:
  - trap_ack and red_hit in the same cycle in RED_TRAP: red wins -> HALT.
  - trap_ack and red_hit in YEL_TRAP: red wins -> RED_ABORT.
  - instr_end and red_hit in YEL_PEND: red wins.
- trap_vec = VEC when trap_req, else 0. sp_value = RED_SP always.

Optional Feature:
- Macro KJ11_STK_ERR_REG_EN.
- Defined: err_bits[1] set on entry to RED_ABORT, err_bits[0] set on entry to YEL_PEND. Bits are sticky (set dominates clear in the same cycle) and are cleared by err_clr, init, or reset_n. They feed the CPU error register, bits 2 (red) and 3 (yellow).
- Undefined: err_bits tied to 2'b00; err_clr ignored.

Test Plan:
- Yellow trap: reset_n low 3 cycles, then high; stk_ref=1, eovfl=1; 4 cycles later instr_end -> trap_req rises next cycle with trap_vec=8'o004; trap_ack -> trap_req=0, state IDLE, no red_abort/force_sp pulses.
- Red sequence: stk_ref=1, eovfl_stop=1 at edge N -> red_abort=1 only in N+1, force_sp=1 only in N+2 with sp_value=16'o000004, trap_req=1 from N+3 until trap_ack.
- Preemption: yel_hit, then red_hit before instr_end -> red sequence only; exactly one trap_req; err_bits=2'b11 when KJ11_STK_ERR_REG_EN is defined.
- Double error: in RED_TRAP, stk_ref=1, eovfl_stop=1 same cycle as trap_ack -> halt_req=1, trap_req=0; stays 1 for 20 cycles; init -> halt_req=0, IDLE.
- Async reset: drop reset_n during RED_LOADSP between clock edges -> force_sp, trap_req and all outputs 0 immediately; on release, state IDLE.
- ckovf gating: in YEL_TRAP with stk_ref=1 -> ckovf=0; in IDLE with stk_ref=1 -> ckovf=1; with stk_ref=0 -> ckovf=0.
